// File: rtl/osc_pkg.sv
// ----------------------------------------------------------------------------
// osc_pkg
// Shared definitions for the oscilloscope capture path: default geometry,
// capture FSM state encodings and trigger edge-mode constants.
// ----------------------------------------------------------------------------
package osc_pkg;

    localparam int OSC_DATA_WIDTH = 32;
    localparam int OSC_CH_NUM     = 4;
    localparam int OSC_ADDR_WIDTH = 18;

    // Encodings are visible to software through o_state, so they are fixed.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE      = 3'd1,
        ST_WAIT_TRG = 3'd2,
        ST_POST     = 3'd3,
        ST_DONE     = 3'd4
    } osc_state_e;

    localparam logic TRG_RISING  = 1'b0;
    localparam logic TRG_FALLING = 1'b1;

    function automatic logic state_is_busy(input osc_state_e st);
        return (st == ST_PRE) || (st == ST_WAIT_TRG) || (st == ST_POST);
    endfunction

endpackage

// File: rtl/osc_trg_detect.sv
// ----------------------------------------------------------------------------
// osc_trg_detect
// Selects the trigger channel out of the packed sample word, remembers the
// previous accepted sample on that channel and compares the pair against the
// trigger level as signed values.
//
// Ports
//   i_clk, i_rst_n  clock, async active-low reset
//   i_clr           clear the previous-sample history (capture start)
//   i_smp_en        current sample is accepted; it becomes the previous sample
//   i_smp_data      all channels, ch0 in LSBs
//   i_trg_ch        channel to watch
//   i_trg_val       trigger level (signed)
//   i_trg_mode      0 rising, 1 falling
//   o_hit           combinational: current sample completes a trigger edge
// ----------------------------------------------------------------------------
module osc_trg_detect
    import osc_pkg::*;
#(
    parameter int DATA_WIDTH = OSC_DATA_WIDTH,
    parameter int CH_NUM     = OSC_CH_NUM,
    localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clr,
    input  logic                         i_smp_en,
    input  logic [CH_NUM*DATA_WIDTH-1:0] i_smp_data,
    input  logic [CH_W-1:0]              i_trg_ch,
    input  logic [DATA_WIDTH-1:0]        i_trg_val,
    input  logic                         i_trg_mode,
    output logic                         o_hit
);

    logic signed [DATA_WIDTH-1:0] cur_smp;
    logic signed [DATA_WIDTH-1:0] prev_smp;
    logic signed [DATA_WIDTH-1:0] trg_lvl;
    logic                         prev_valid;
    logic                         rise_hit;
    logic                         fall_hit;

    always_comb begin
        cur_smp = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (i_trg_ch == CH_W'(i)) begin
                cur_smp = i_smp_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_smp   <= '0;
            prev_valid <= 1'b0;
        end else if (i_clr) begin
            prev_smp   <= '0;
            prev_valid <= 1'b0;
        end else if (i_smp_en) begin
            prev_smp   <= cur_smp;
            prev_valid <= 1'b1;
        end
    end

    assign trg_lvl  = i_trg_val;
    assign rise_hit = (prev_smp < trg_lvl) && (cur_smp >= trg_lvl);
    assign fall_hit = (prev_smp > trg_lvl) && (cur_smp <= trg_lvl);
    assign o_hit    = prev_valid && ((i_trg_mode == TRG_FALLING) ? fall_hit : rise_hit);

endmodule

// File: rtl/osc_capture_ctrl.sv
// ----------------------------------------------------------------------------
// osc_capture_ctrl
// Sequences a capture into a circular sample RAM: pre-trigger fill, trigger
// wait, post-trigger fill, done. Every accepted sample is written one cycle
// later through a registered write port.
//
// Ports
//   i_clk, i_rst_n    clock, async active-low reset
//   i_arm, i_abort    1-cycle start / stop pulses (abort wins)
//   i_trg_val/_ch/_mode  trigger config, latched at arm
//   i_pre_len         pre-trigger sample count, latched at arm
//   i_smp_valid/_data sample stream, ch0 in LSBs
//   o_wr_en/_addr/_data  capture RAM write port
//   o_osc_cnt         samples written since arm, saturating at DEPTH-1
//   o_osc_trg_cnt     RAM address of the trigger sample
//   o_busy, o_done, o_state  status
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no capture; waits for arm
// PRE      | filling pre-trigger samples, trigger detection masked
// WAIT_TRG | writing samples until the trigger edge is seen
// POST     | writing the remaining post-trigger samples
// DONE     | capture complete, counters held for readback
// ----------------------------------------------------------------------------
module osc_capture_ctrl
    import osc_pkg::*;
#(
    parameter int DATA_WIDTH = OSC_DATA_WIDTH,
    parameter int CH_NUM     = OSC_CH_NUM,
    parameter int ADDR_WIDTH = OSC_ADDR_WIDTH,
    localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_arm,
    input  logic                         i_abort,
    input  logic [DATA_WIDTH-1:0]        i_trg_val,
    input  logic [CH_W-1:0]              i_trg_ch,
    input  logic                         i_trg_mode,
    input  logic [ADDR_WIDTH-1:0]        i_pre_len,
    input  logic                         i_smp_valid,
    input  logic [CH_NUM*DATA_WIDTH-1:0] i_smp_data,
    output logic                         o_wr_en,
    output logic [ADDR_WIDTH-1:0]        o_wr_addr,
    output logic [CH_NUM*DATA_WIDTH-1:0] o_wr_data,
    output logic [ADDR_WIDTH-1:0]        o_osc_cnt,
    output logic [ADDR_WIDTH-1:0]        o_osc_trg_cnt,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [2:0]                   o_state
);

    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;   // DEPTH-1
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

    osc_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0]        trg_val_q;
    logic [CH_W-1:0]              trg_ch_q;
    logic                         trg_mode_q;
    logic [ADDR_WIDTH-1:0]        pre_len_q;
    logic [ADDR_WIDTH-1:0]        pre_rem_q;
    logic [ADDR_WIDTH-1:0]        post_rem_q;
    logic [ADDR_WIDTH-1:0]        post_len;
    logic [ADDR_WIDTH-1:0]        ptr_q;
    logic [ADDR_WIDTH-1:0]        osc_cnt_q;
    logic [ADDR_WIDTH-1:0]        osc_trg_cnt_q;
    logic                         wr_en_q;
    logic [ADDR_WIDTH-1:0]        wr_addr_q;
    logic [CH_NUM*DATA_WIDTH-1:0] wr_data_q;

    logic busy;
    logic accept;
    logic arm_go;
    logic trg_fire;
    logic trg_hit;

    // i_pre_len is ADDR_WIDTH bits wide, so it can never exceed DEPTH-1 and
    // the clamp to DEPTH-1 is inherent in the port width.
    assign post_len = CNT_MAX - pre_len_q;

    assign busy   = state_is_busy(state_q);
    assign accept = busy && i_smp_valid && !i_abort;

    osc_trg_detect #(
        .DATA_WIDTH (DATA_WIDTH),
        .CH_NUM     (CH_NUM)
    ) u_trg_detect (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (arm_go),
        .i_smp_en   (accept),
        .i_smp_data (i_smp_data),
        .i_trg_ch   (trg_ch_q),
        .i_trg_val  (trg_val_q),
        .i_trg_mode (trg_mode_q),
        .o_hit      (trg_hit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        arm_go   = 1'b0;
        trg_fire = 1'b0;
        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_arm) begin
                        arm_go  = 1'b1;
                        state_d = (i_pre_len == '0) ? ST_WAIT_TRG : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (accept && (pre_rem_q == CNT_ONE)) begin
                        state_d = ST_WAIT_TRG;
                    end
                end
                ST_WAIT_TRG: begin
                    if (accept && trg_hit) begin
                        trg_fire = 1'b1;
                        state_d  = (post_len == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (accept && (post_rem_q == CNT_ONE)) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            trg_val_q     <= '0;
            trg_ch_q      <= '0;
            trg_mode_q    <= 1'b0;
            pre_len_q     <= '0;
            pre_rem_q     <= '0;
            post_rem_q    <= '0;
            ptr_q         <= '0;
            osc_cnt_q     <= '0;
            osc_trg_cnt_q <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            wr_en_q <= accept;

            if (arm_go) begin
                trg_val_q     <= i_trg_val;
                trg_ch_q      <= i_trg_ch;
                trg_mode_q    <= i_trg_mode;
                pre_len_q     <= i_pre_len;
                pre_rem_q     <= i_pre_len;
                ptr_q         <= '0;
                osc_cnt_q     <= '0;
                osc_trg_cnt_q <= '0;
            end

            if (accept) begin
                wr_addr_q <= ptr_q;
                wr_data_q <= i_smp_data;
                ptr_q     <= ptr_q + CNT_ONE;   // natural wrap DEPTH-1 -> 0
                if (osc_cnt_q != CNT_MAX) begin
                    osc_cnt_q <= osc_cnt_q + CNT_ONE;
                end
            end

            if (accept && (state_q == ST_PRE)) begin
                pre_rem_q <= pre_rem_q - CNT_ONE;
            end

            if (trg_fire) begin
                osc_trg_cnt_q <= ptr_q;
                post_rem_q    <= post_len;
            end

            if (accept && (state_q == ST_POST)) begin
                post_rem_q <= post_rem_q - CNT_ONE;
            end
        end
    end

    assign o_wr_en       = wr_en_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_wr_data     = wr_data_q;
    assign o_osc_cnt     = osc_cnt_q;
    assign o_osc_trg_cnt = osc_trg_cnt_q;
    assign o_busy        = busy;
    assign o_done        = (state_q == ST_DONE);
    assign o_state       = state_q;

endmodule

// File: tb/tb_osc_capture_ctrl.sv
module tb_osc_capture_ctrl;

    localparam int DW = 32;
    localparam int CN = 4;
    localparam int AW = 4;
    localparam int CW = 2;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_arm = 1'b0;
    logic              i_abort = 1'b0;
    logic [DW-1:0]     i_trg_val = '0;
    logic [CW-1:0]     i_trg_ch = '0;
    logic              i_trg_mode = 1'b0;
    logic [AW-1:0]     i_pre_len = '0;
    logic              i_smp_valid = 1'b0;
    logic [CN*DW-1:0]  i_smp_data = '0;
    logic              o_wr_en;
    logic [AW-1:0]     o_wr_addr;
    logic [CN*DW-1:0]  o_wr_data;
    logic [AW-1:0]     o_osc_cnt;
    logic [AW-1:0]     o_osc_trg_cnt;
    logic              o_busy;
    logic              o_done;
    logic [2:0]        o_state;

    osc_capture_ctrl #(
        .DATA_WIDTH (DW),
        .CH_NUM     (CN),
        .ADDR_WIDTH (AW)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_arm         (i_arm),
        .i_abort       (i_abort),
        .i_trg_val     (i_trg_val),
        .i_trg_ch      (i_trg_ch),
        .i_trg_mode    (i_trg_mode),
        .i_pre_len     (i_pre_len),
        .i_smp_valid   (i_smp_valid),
        .i_smp_data    (i_smp_data),
        .o_wr_en       (o_wr_en),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data),
        .o_osc_cnt     (o_osc_cnt),
        .o_osc_trg_cnt (o_osc_trg_cnt),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_state       (o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [CN*DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int            n_cmp = 0;
    int            n_mis = 0;
    int            seq = 0;
    logic [AW-1:0] exp_ptr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [CN*DW-1:0] mk_data(input int ch, input int val);
        logic [CN*DW-1:0] d;
        logic [DW-1:0]    fill;
        d = '0;
        for (int k = 0; k < CN; k++) begin
            fill = 32'hA000_0000 | (DW'(k) << 16) | DW'(seq & 16'hFFFF);
            d[k*DW +: DW] = fill;
        end
        d[ch*DW +: DW] = DW'(val);
        return d;
    endfunction

    // One sample on the stream; when a write is expected it is queued with
    // the address the capture pointer should have at that point.
    task automatic smp(input int ch, input int val, input bit expect_wr);
        logic [CN*DW-1:0] d;
        d = mk_data(ch, val);
        seq++;
        i_smp_data  = d;
        i_smp_valid = 1'b1;
        if (expect_wr) begin
            exp_q.push_back('{addr: exp_ptr, data: d});
            exp_ptr = exp_ptr + 1'b1;
        end
        @(posedge i_clk);
        #1;
        i_smp_valid = 1'b0;
    endtask

    task automatic arm(input int val, input int ch, input bit mode, input int pre);
        i_trg_val  = DW'(val);
        i_trg_ch   = CW'(ch);
        i_trg_mode = mode;
        i_pre_len  = AW'(pre);
        i_arm      = 1'b1;
        @(posedge i_clk);
        #1;
        i_arm   = 1'b0;
        exp_ptr = '0;
    endtask

    // Monitor: every presented write must match the oldest expected entry.
    initial begin
        wr_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_wr_en) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_write: got write at addr %0d, expected no write", o_wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (o_wr_addr !== e.addr || o_wr_data !== e.data) begin
                        n_mis++;
                        $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                                 o_wr_addr, o_wr_data, e.addr, e.data);
                    end
                end
            end
        end
    end

    int d_seq[15] = '{-100, -90, -80, -70, -60, 50, -50, -40, -30, -20, -15, -12, -10, -9, -8};

    initial begin
        // reset values
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_state", o_state, 0);
        check("rst_wr_en", o_wr_en, 0);
        check("rst_busy_done", {o_busy, o_done}, 0);
        check("rst_cnts", {o_osc_cnt, o_osc_trg_cnt}, 0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // rising edge on ch1, level 100, 4 pre samples
        arm(100, 1, 1'b0, 4);
        check("a_state_pre", o_state, 1);
        smp(1, 0, 1); smp(1, 30, 1); smp(1, 60, 1); smp(1, 90, 1);
        check("a_state_wait", o_state, 2);
        smp(1, 120, 1);
        check("a_state_post", o_state, 3);
        check("a_trg_cnt", o_osc_trg_cnt, 4);
        check("a_osc_cnt5", o_osc_cnt, 5);
        for (int i = 0; i < 11; i++) begin
            smp(1, 150 + 30 * i, 1);
            if (i == 9) check("a_post_last_but_one", o_state, 3);
        end
        check("a_state_done", o_state, 4);
        check("a_done_busy", {o_done, o_busy}, 2'b10);
        check("a_osc_cnt", o_osc_cnt, 15);
        check("a_trg_cnt_hold", o_osc_trg_cnt, 4);
        smp(1, 999, 0);

        // falling edge on ch2, no pre samples; config changed after arm
        arm(100, 2, 1'b1, 0);
        check("b_state_wait", o_state, 2);
        i_trg_val  = 300;
        i_trg_mode = 1'b0;
        i_trg_ch   = 1;
        smp(2, 50, 1);
        check("b_first_no_trg", o_state, 2);
        smp(2, 200, 1);
        check("b_rise_no_trg", o_state, 2);
        smp(2, 90, 1);
        check("b_state_post", o_state, 3);
        check("b_trg_cnt", o_osc_trg_cnt, 2);
        for (int i = 0; i < 15; i++) begin
            smp(2, 80 - i, 1);
            if (i == 13) check("b_post_14", o_state, 3);
        end
        check("b_state_done", o_state, 4);
        check("b_osc_cnt", o_osc_cnt, 15);

        // no trigger for 40 samples: pointer wraps, count saturates
        arm(100, 1, 1'b0, 4);
        for (int i = 0; i < 40; i++) begin
            smp(1, 10, 1);
            if (i == 3) check("c_state_wait", o_state, 2);
        end
        check("c_still_wait", o_state, 2);
        check("c_busy", o_busy, 1);
        check("c_osc_cnt_sat", o_osc_cnt, 15);
        smp(1, 120, 1);
        check("c_state_post", o_state, 3);
        check("c_trg_cnt_wrap", o_osc_trg_cnt, 8);
        // arm while busy is ignored
        i_pre_len = '0;
        i_arm = 1'b1;
        @(posedge i_clk);
        #1;
        i_arm = 1'b0;
        check("c_arm_ignored", o_state, 3);
        // abort with a sample in the same cycle: nothing written
        i_smp_data  = mk_data(1, 555);
        i_smp_valid = 1'b1;
        i_abort     = 1'b1;
        @(posedge i_clk);
        #1;
        i_smp_valid = 1'b0;
        i_abort     = 1'b0;
        check("c_abort_idle", o_state, 0);
        check("c_abort_no_wr", o_wr_en, 0);
        check("c_abort_cnt_hold", {o_osc_cnt, o_osc_trg_cnt}, {4'd15, 4'd8});

        // arm and abort together: abort wins
        i_pre_len = 4;
        i_arm     = 1'b1;
        i_abort   = 1'b1;
        @(posedge i_clk);
        #1;
        i_arm   = 1'b0;
        i_abort = 1'b0;
        check("e_arm_abort_idle", o_state, 0);

        // maximum pre length, signed level, crossing in PRE ignored
        arm(-5, 3, 1'b0, 15);
        for (int i = 0; i < 15; i++) begin
            smp(3, d_seq[i], 1);
            if (i == 5) check("d_pre_masked", o_state, 1);
        end
        check("d_state_wait", o_state, 2);
        smp(3, 20, 1);
        check("d_state_done", o_state, 4);
        check("d_trg_cnt", o_osc_trg_cnt, 15);
        check("d_osc_cnt", o_osc_cnt, 15);

        // reset while in POST with a write on the port
        arm(0, 0, 1'b0, 0);
        smp(0, -1, 1);
        smp(0, 1, 1);
        check("r_state_post", o_state, 3);
        check("r_trg_cnt", o_osc_trg_cnt, 1);
        smp(0, 5, 0);
        i_rst_n = 1'b0;
        #1;
        check("r_wr_en", o_wr_en, 0);
        check("r_state", o_state, 0);
        check("r_busy_done", {o_busy, o_done}, 0);
        check("r_cnts", {o_osc_cnt, o_osc_trg_cnt}, 0);
        check("r_wr_addr", o_wr_addr, 0);
        check("r_wr_data_zero", (o_wr_data == '0), 1);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        repeat (3) @(posedge i_clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
